// File: rtl/im_fetch_pkg.sv
// Shared IM/PC constants, fetch entry layout and the address check used by the fetch path.
package im_fetch_pkg;

    localparam logic [31:0] IMF_PC_START   = 32'h0000_3000;
    localparam logic [31:0] IMF_ADDR_LB    = 32'h0000_3000;
    localparam logic [31:0] IMF_ADDR_UB    = 32'h0000_6ffc;
    localparam logic [31:0] IMF_ISR_ADDR   = 32'h0000_4180;
    localparam int          IMF_ADDR_WIDTH = 12;
    localparam int          IMF_ENTRY_W    = 65;

    typedef enum logic {
        ST_RUN  = 1'b0,
        ST_HALT = 1'b1
    } fetch_state_e;

    typedef struct packed {
        logic        fault;
        logic [31:0] pc;
        logic [31:0] instr;
    } fetch_entry_t;

    function automatic logic addr_in_range(
        input logic [31:0] pc,
        input logic [31:0] lb,
        input logic [31:0] ub
    );
        return (pc >= lb) && (pc <= ub) && (pc[1:0] == 2'b00);
    endfunction

endpackage

// File: rtl/im_fetch_buf.sv
// Output register plus one skid slot; an empty output register passes the live
// memory response straight through so issue-to-valid latency is one cycle.
module im_fetch_buf
    import im_fetch_pkg::*;
(
    input  logic                   clk,
    input  logic                   i_reset,
    input  logic                   i_flush,
    input  logic                   i_in_valid,
    input  logic [IMF_ENTRY_W-1:0] i_in_data,
    input  logic                   i_out_ready,
    output logic                   o_out_valid,
    output logic [IMF_ENTRY_W-1:0] o_out_data,
    output logic                   o_skid_valid
);

    logic                   r_out_valid;
    logic [IMF_ENTRY_W-1:0] r_out_data;
    logic                   r_skid_valid;
    logic [IMF_ENTRY_W-1:0] r_skid_data;
    logic                   w_bypass;

    assign w_bypass     = !r_out_valid && i_in_valid;
    assign o_out_valid  = r_out_valid || i_in_valid;
    assign o_out_data   = w_bypass ? i_in_data : r_out_data;
    assign o_skid_valid = r_skid_valid;

    always_ff @(posedge clk) begin
        if (i_reset || i_flush) begin
            r_out_valid  <= 1'b0;
            r_out_data   <= '0;
            r_skid_valid <= 1'b0;
            r_skid_data  <= '0;
        end else if (!r_out_valid) begin
            // Bypassed response that decode did not take must be captured now.
            if (i_in_valid && !i_out_ready) begin
                r_out_valid <= 1'b1;
                r_out_data  <= i_in_data;
            end
        end else if (i_out_ready) begin
            if (r_skid_valid) begin
                r_out_data   <= r_skid_data;
                r_skid_valid <= i_in_valid;
                r_skid_data  <= i_in_data;
            end else if (i_in_valid) begin
                r_out_data <= i_in_data;
            end else begin
                r_out_valid <= 1'b0;
            end
        end else if (i_in_valid) begin
            r_skid_valid <= 1'b1;
            r_skid_data  <= i_in_data;
        end
    end

endmodule

// File: rtl/im_fetch_ctrl.sv
// Fetch controller: owns the fetch PC, issues one IM read per cycle, flags bad
// addresses and hands {pc, instr, fault} to decode through im_fetch_buf.
module im_fetch_ctrl
    import im_fetch_pkg::*;
#(
    parameter logic [31:0] PC_START      = IMF_PC_START,
    parameter logic [31:0] ADDR_LB       = IMF_ADDR_LB,
    parameter logic [31:0] ADDR_UB       = IMF_ADDR_UB,
    parameter int          IM_ADDR_WIDTH = IMF_ADDR_WIDTH
)(
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     redirect_valid,
    input  logic [31:0]              redirect_pc,
    output logic                     mem_en,
    output logic [IM_ADDR_WIDTH-1:0] mem_addr,
    input  logic [31:0]              mem_rdata,
    output logic                     out_valid,
    input  logic                     out_ready,
    output logic [31:0]              out_pc,
    output logic [31:0]              out_instr,
    output logic                     out_fault
);

    fetch_state_e r_state, w_state_next;
    logic [31:0]  r_fetch_pc, w_fetch_pc_next;
    logic         r_inflight, w_inflight_next;
    logic         r_inflight_fault, w_inflight_fault_next;
    logic [31:0]  r_inflight_pc, w_inflight_pc_next;

    logic         w_addr_ok;
    logic         w_issue;
    logic         w_skid_valid;
    logic [31:0]  w_diff;
    logic         w_unused;
    fetch_entry_t w_resp;
    fetch_entry_t w_out;

    assign w_addr_ok = addr_in_range(r_fetch_pc, ADDR_LB, ADDR_UB);
    assign w_diff    = r_fetch_pc - ADDR_LB;
    assign w_unused  = &{1'b0, w_diff[31:IM_ADDR_WIDTH+2], w_diff[1:0]};

    // Hold off when the pending response would find both buffer slots occupied.
    assign w_issue = (r_state == ST_RUN) && !redirect_valid && !w_skid_valid
                     && !(r_inflight && out_valid && !out_ready);

    assign mem_en   = !reset && w_issue && w_addr_ok;
    assign mem_addr = reset ? '0 : w_diff[IM_ADDR_WIDTH+1:2];

    always_comb begin
        w_state_next          = r_state;
        w_fetch_pc_next       = r_fetch_pc;
        w_inflight_next       = 1'b0;
        w_inflight_fault_next = 1'b0;
        w_inflight_pc_next    = r_fetch_pc;
        if (redirect_valid) begin
            w_state_next    = ST_RUN;
            w_fetch_pc_next = redirect_pc;
        end else if (w_issue) begin
            w_inflight_next = 1'b1;
            if (w_addr_ok) begin
                w_fetch_pc_next = r_fetch_pc + 32'd4;
            end else begin
                w_inflight_fault_next = 1'b1;
                w_state_next          = ST_HALT;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state          <= ST_RUN;
            r_fetch_pc       <= PC_START;
            r_inflight       <= 1'b0;
            r_inflight_fault <= 1'b0;
            r_inflight_pc    <= '0;
        end else begin
            r_state          <= w_state_next;
            r_fetch_pc       <= w_fetch_pc_next;
            r_inflight       <= w_inflight_next;
            r_inflight_fault <= w_inflight_fault_next;
            r_inflight_pc    <= w_inflight_pc_next;
        end
    end

    assign w_resp = '{fault: r_inflight_fault,
                      pc:    r_inflight_pc,
                      instr: r_inflight_fault ? 32'd0 : mem_rdata};

    im_fetch_buf u_buf (
        .clk          (clk),
        .i_reset      (reset),
        .i_flush      (redirect_valid),
        .i_in_valid   (r_inflight),
        .i_in_data    (w_resp),
        .i_out_ready  (out_ready),
        .o_out_valid  (out_valid),
        .o_out_data   (w_out),
        .o_skid_valid (w_skid_valid)
    );

    assign out_pc    = w_out.pc;
    assign out_instr = w_out.instr;
    assign out_fault = w_out.fault;

endmodule

// File: tb/tb_im_fetch_ctrl.sv
// Bench for im_fetch_ctrl: directed table of redirect targets, hand-written
// corner sequences, then random traffic against a stream-level fetch model.
module tb_im_fetch_ctrl;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        redirect_valid = 1'b0;
    logic [31:0] redirect_pc = 32'd0;
    logic        mem_en;
    logic [11:0] mem_addr;
    logic [31:0] mem_rdata = 32'd0;
    logic        out_valid;
    logic        out_ready = 1'b0;
    logic [31:0] out_pc;
    logic [31:0] out_instr;
    logic        out_fault;

    int n_tests = 0;
    int n_fail  = 0;

    logic [31:0] mem [4096];

    im_fetch_ctrl dut (
        .clk            (clk),
        .reset          (reset),
        .redirect_valid (redirect_valid),
        .redirect_pc    (redirect_pc),
        .mem_en         (mem_en),
        .mem_addr       (mem_addr),
        .mem_rdata      (mem_rdata),
        .out_valid      (out_valid),
        .out_ready      (out_ready),
        .out_pc         (out_pc),
        .out_instr      (out_instr),
        .out_fault      (out_fault)
    );

    always #5 clk = ~clk;

    always @(posedge clk) begin
        if (mem_en) mem_rdata <= mem[mem_addr];
    end

    function automatic logic [31:0] word_at(input logic [31:0] pc);
        logic [31:0] d;
        d = (pc - 32'h0000_3000) >> 2;
        return 32'h5A00_0000 ^ ((d & 32'h0000_0FFF) * 32'h0001_0103);
    endfunction

    function automatic logic addr_ok(input logic [31:0] pc);
        return (pc >= 32'h0000_3000) && (pc <= 32'h0000_6ffc) && (pc[1:0] == 2'b00);
    endfunction

    function automatic logic [11:0] word_idx(input logic [31:0] pc);
        logic [31:0] d;
        d = (pc - 32'h0000_3000) >> 2;
        return d[11:0];
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // One clock cycle: apply inputs just after the edge, sample outputs 1ns later.
    task automatic cyc(input logic rst, input logic rv, input logic [31:0] rpc, input logic rdy);
        @(posedge clk);
        #1;
        reset          = rst;
        redirect_valid = rv;
        redirect_pc    = rpc;
        out_ready      = rdy;
        #1;
    endtask

    task automatic chk_reset_values(input string tag);
        chk({tag, "_out_valid"}, out_valid, 0);
        chk({tag, "_out_pc"},    out_pc,    0);
        chk({tag, "_out_instr"}, out_instr, 0);
        chk({tag, "_out_fault"}, out_fault, 0);
        chk({tag, "_mem_en"},    mem_en,    0);
        chk({tag, "_mem_addr"},  mem_addr,  0);
    endtask

    typedef struct {
        logic [31:0] target;
        logic        exp_fault;
        logic        exp_mem_en;
        logic [11:0] exp_addr;
    } vec_t;

    vec_t vecs [8];

    logic [31:0] p_val;
    logic [31:0] m_issue, m_out;
    logic        m_done;
    logic        p_hold;
    logic [31:0] p_pc, p_instr;
    logic        p_fault;
    logic        rv, rdy;
    logic [31:0] rpc;
    int          accepted;
    int          sel;

    initial begin
        for (int i = 0; i < 4096; i++) mem[i] = word_at(32'h0000_3000 + 32'(i) * 4);

        vecs[0] = '{32'h0000_4180, 1'b0, 1'b1, 12'h460};
        vecs[1] = '{32'h0000_2ffc, 1'b1, 1'b0, 12'h000};
        vecs[2] = '{32'h0000_3002, 1'b1, 1'b0, 12'h000};
        vecs[3] = '{32'h0000_3000, 1'b0, 1'b1, 12'h000};
        vecs[4] = '{32'h0000_6ffc, 1'b0, 1'b1, 12'hfff};
        vecs[5] = '{32'h0000_7000, 1'b1, 1'b0, 12'h000};
        vecs[6] = '{32'h0000_6ff8, 1'b0, 1'b1, 12'hffe};
        vecs[7] = '{32'hffff_fffc, 1'b1, 1'b0, 12'h000};

        // Reset state, then streaming start with out_ready high.
        cyc(1, 0, 0, 1);
        cyc(1, 0, 0, 1);
        cyc(1, 0, 0, 1);
        chk_reset_values("reset");
        cyc(0, 0, 0, 1);
        chk("start_mem_en", mem_en, 1);
        chk("start_addr", mem_addr, 0);
        chk("start_no_valid", out_valid, 0);
        for (int j = 0; j < 6; j++) begin
            cyc(0, 0, 0, 1);
            chk("stream_valid", out_valid, 1);
            chk("stream_pc", out_pc, 32'h3000 + 32'(j) * 4);
            chk("stream_instr", out_instr, word_at(32'h3000 + 32'(j) * 4));
            chk("stream_mem_addr", mem_addr, 12'(j + 1));
        end

        // Three-cycle stall: held entry stable, then gap-free resume.
        p_val = 32'h0000_3018;
        for (int j = 0; j < 3; j++) begin
            cyc(0, 0, 0, 0);
            chk("stall_valid", out_valid, 1);
            chk("stall_pc", out_pc, p_val);
            chk("stall_instr", out_instr, word_at(p_val));
        end
        chk("stall_mem_en", mem_en, 0);
        for (int j = 0; j < 4; j++) begin
            cyc(0, 0, 0, 1);
            chk("resume_valid", out_valid, 1);
            chk("resume_pc", out_pc, p_val + 32'(j) * 4);
        end

        // Redirect table, each applied with the output full and a read inflight.
        for (int i = 0; i < 8; i++) begin
            cyc(0, 0, 0, 0);
            cyc(0, 0, 0, 0);
            cyc(0, 1, vecs[i].target, 0);
            chk("redir_no_issue", mem_en, 0);
            cyc(0, 0, 0, 1);
            chk("redir_t1_valid", out_valid, 0);
            chk("redir_t1_mem_en", mem_en, vecs[i].exp_mem_en);
            if (vecs[i].exp_mem_en) chk("redir_t1_addr", mem_addr, vecs[i].exp_addr);
            cyc(0, 0, 0, 1);
            chk("redir_t2_valid", out_valid, 1);
            chk("redir_t2_pc", out_pc, vecs[i].target);
            chk("redir_t2_fault", out_fault, vecs[i].exp_fault);
            chk("redir_t2_instr", out_instr, vecs[i].exp_fault ? 32'd0 : word_at(vecs[i].target));
            if (vecs[i].exp_fault) begin
                cyc(0, 0, 0, 1);
                chk("halt_valid", out_valid, 0);
                chk("halt_mem_en", mem_en, 0);
                cyc(0, 0, 0, 1);
                chk("halt_mem_en2", mem_en, 0);
            end
        end

        // Sequential fetch running off the top of the IM range.
        cyc(0, 1, 32'h0000_6ff8, 1);
        cyc(0, 0, 0, 1);
        chk("top_t1_addr", mem_addr, 12'hffe);
        cyc(0, 0, 0, 1);
        chk("top_e0_pc", out_pc, 32'h0000_6ff8);
        chk("top_e0_fault", out_fault, 0);
        chk("top_t2_addr", mem_addr, 12'hfff);
        cyc(0, 0, 0, 1);
        chk("top_e1_pc", out_pc, 32'h0000_6ffc);
        chk("top_e1_instr", out_instr, word_at(32'h0000_6ffc));
        chk("top_e1_mem_en", mem_en, 0);
        cyc(0, 0, 0, 1);
        chk("top_e2_valid", out_valid, 1);
        chk("top_e2_pc", out_pc, 32'h0000_7000);
        chk("top_e2_fault", out_fault, 1);
        chk("top_e2_instr", out_instr, 0);
        cyc(0, 0, 0, 1);
        chk("top_halt_valid", out_valid, 0);
        chk("top_halt_mem_en", mem_en, 0);

        // Reset while backpressured with the skid full.
        cyc(0, 1, 32'h0000_3000, 1);
        for (int j = 0; j < 4; j++) cyc(0, 0, 0, 1);
        for (int j = 0; j < 3; j++) cyc(0, 0, 0, 0);
        cyc(1, 0, 0, 0);
        chk("rst_mid_mem_en", mem_en, 0);
        cyc(1, 0, 0, 1);
        chk_reset_values("rst_mid");
        cyc(0, 0, 0, 1);
        chk("rst_mid_restart_addr", mem_addr, 0);
        chk("rst_mid_restart_en", mem_en, 1);
        cyc(0, 0, 0, 1);
        chk("rst_mid_restart_pc", out_pc, 32'h0000_3000);

        // Random traffic against the stream model.
        cyc(1, 0, 0, 0);
        cyc(1, 0, 0, 0);
        m_issue  = 32'h0000_3000;
        m_out    = 32'h0000_3000;
        m_done   = 1'b0;
        p_hold   = 1'b0;
        p_pc     = 32'd0;
        p_instr  = 32'd0;
        p_fault  = 1'b0;
        accepted = 0;
        for (int it = 0; it < 2000; it++) begin
            rdy = ($urandom_range(0, 3) != 0);
            rv  = ($urandom_range(0, 15) == 0);
            sel = int'($urandom_range(0, 9));
            case (sel)
                0:       rpc = 32'h0000_2ffc;
                1:       rpc = 32'h0000_3002;
                2:       rpc = 32'h0000_7000;
                3:       rpc = 32'h0000_6ff8;
                default: rpc = 32'h0000_3000 + ($urandom_range(0, 4095) << 2);
            endcase
            cyc(0, rv, rpc, rdy);
            if (p_hold) begin
                chk("rnd_hold_valid", out_valid, 1);
                chk("rnd_hold_pc", out_pc, p_pc);
                chk("rnd_hold_instr", out_instr, p_instr);
                chk("rnd_hold_fault", out_fault, p_fault);
            end
            if (rv) chk("rnd_redir_no_issue", mem_en, 0);
            if (mem_en) begin
                chk("rnd_issue_legal", addr_ok(m_issue), 1);
                chk("rnd_issue_addr", mem_addr, word_idx(m_issue));
                m_issue = m_issue + 32'd4;
            end
            if (out_valid && rdy) begin
                chk("rnd_entry_expected", m_done, 0);
                chk("rnd_pc", out_pc, m_out);
                chk("rnd_fault", out_fault, !addr_ok(m_out));
                chk("rnd_instr", out_instr, addr_ok(m_out) ? word_at(m_out) : 32'd0);
                accepted++;
                if (addr_ok(m_out)) m_out = m_out + 32'd4;
                else m_done = 1'b1;
            end
            p_hold  = out_valid && !rdy && !rv;
            p_pc    = out_pc;
            p_instr = out_instr;
            p_fault = out_fault;
            if (rv) begin
                m_issue = rpc;
                m_out   = rpc;
                m_done  = 1'b0;
            end
        end
        chk("rnd_progress", (accepted >= 200) ? 32'd1 : 32'd0, 1);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
